cam_bank_assoc: RTL and testbench
=================================

Name: cam_bank_assoc

Overview:
Parametrised successor to the single-mode CAM bank: an N-way set-associative exact-match lookup table with a fixed-latency probe pipeline.
- The probe side returns match_id/len on hit.
- The config side supports insert/update/delete, with round-robin victim replacement when a set is full.
- Hit/miss statistics counters are included.
- Sits between the packet-parsing front end (probe source) and the dictionary manager (config source).

Parameters:
- KEY_WIDTH, 96, probe/config key width in bits.
- ID_WIDTH, 32, match identifier width.
- LEN_WIDTH, 8, match length width.
- NUM_SETS, 64, number of sets; power of two, ≥2.
- WAYS, 4, entries per set; power of two, ≥1.
- SET_BITS, log2(NUM_SETS), derived, not overridden.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, synchronous active-low reset.
- probe_key, in, KEY_WIDTH, lookup key.
- probe_valid, in, 1, probe request.
- probe_last, in, 1, marks last probe of a burst.
- probe_ready, out, 1, probe accepted when probe_valid&probe_ready.
- match_valid, out, 1, result strobe, one cycle per accepted probe.
- match_hit, out, 1, key found.
- match_id, out, ID_WIDTH, stored id (0 on miss).
- match_len, out, LEN_WIDTH, stored length (0 on miss).
- match_last, out, 1, probe_last delayed with its result.
- cfg_valid, in, 1, config request.
- cfg_op, in, 1, 0=insert/update, 1=delete.
- cfg_key, in, KEY_WIDTH, config key.
- cfg_match_id, in, ID_WIDTH, id to store.
- cfg_len, in, LEN_WIDTH, length to store.
- cfg_ready, out, 1, config accepted when cfg_valid&cfg_ready.
- cfg_done, out, 1, one-cycle completion pulse.
- cfg_found, out, 1, key existed before the op (valid with cfg_done).
- cfg_evicted, out, 1, insert displaced a valid entry (valid with cfg_done).
- hit_count, out, 32, saturating hit counter.
- miss_count, out, 32, saturating miss counter.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All entries invalid; all per-set round-robin pointers 0; counters 0.
  - FSM to IDLE; pipeline valids cleared.
  - All outputs 0 except probe_ready=1 and cfg_ready=1 on the first cycle after reset release.
  - Reset mid-operation discards in-flight probes/config ops with no result or cfg_done.
- Set index: XOR-fold of the key into SET_BITS chunks (key zero-extended to a multiple of SET_BITS). The same function is used for probe and cfg.
- Probe pipeline, fully pipelined, one probe/cycle, latency exactly 2:
  - Probe accepted at edge T gives match_valid high for the cycle after edge T+2.
  - S1: register key, index and last.
  - S2: compare against all WAYS of the set; register results.
  - Multiple way hits are not expected. If they occur, the lowest way index wins.
- Entry fields: valid, key, id, len.
- Config FSM states and transitions:
  - IDLE -> DRAIN on cfg accept.
  - DRAIN -> LOOKUP once pipeline empty; 0 cycles if already empty.
  - LOOKUP -> COMMIT.
  - COMMIT -> IDLE.
- cfg_ready=1 only in IDLE.
- probe_ready=0 from the cycle after cfg accept until return to IDLE. When cfg_valid and probe_valid are both asserted in IDLE, cfg wins and the probe is not accepted that cycle.
- LOOKUP: compare cfg_key against the set; record hit way, first invalid way, and rr pointer.
- COMMIT, insert:
  - Key hit: overwrite id/len in place; found=1, evicted=0.
  - Miss with an invalid way available: write the lowest invalid way; found=0, evicted=0.
  - Miss with a full set: write way rr[set]; rr[set] = (rr+1) mod WAYS; found=0, evicted=1.
- COMMIT, delete:
  - Hit: clear the valid bit; found=1.
  - Miss: no change; found=0.
- cfg_done pulses in the COMMIT cycle. Probes accepted afterwards see the new contents.
- Counters:
  - hit_count increments on each match_valid&match_hit.
  - miss_count increments on each match_valid&!match_hit.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- Request inputs are sampled only at the accepting edge.

Test Plan:
1. Post-reset probe key 96'hDEADBEEF_11223344_55667788 -> match_valid exactly 2 cycles later, hit=0, id=0, len=0, miss_count=1.
2. Insert key K=96'h1, id 32'hA5, len 8'd12, then probe K -> cfg_done with found=0, evicted=0; probe returns hit=1, id=0xA5, len=12. Re-insert K with id 0x5A -> found=1; probe returns 0x5A.
3. Insert WAYS+1=5 distinct keys mapping to one set (default params) -> 5th insert gives evicted=1; the first-inserted key misses; the other four hit; rr[set]=1.
4. 1000 back-to-back probes with probe_last on the final one -> probe_ready held 1; exactly 1000 match_valid pulses in consecutive cycles; match_last only on the last; hit_count + miss_count = 1000.
5. cfg delete issued while 2 probes are in flight -> both probe results emitted with the pre-delete contents; probe_ready low until cfg_done+1; a subsequent probe misses; delete of an absent key gives found=0.
6. Force miss_count near saturation (preload via 2^32-2 misses, or bench-level force) then 3 misses -> counter holds at 32'hFFFF_FFFF; rst_n low for one cycle mid-burst -> no further match_valid, counters 0.

Source files
------------

// File: rtl/cam_bank_assoc.sv
// Set-associative exact-match CAM: 2-cycle probe pipeline, drained config FSM,
// round-robin victim choice per set, and saturating hit/miss counters.
module cam_bank_assoc #(
    parameter int KEY_WIDTH = 96,
    parameter int ID_WIDTH  = 32,
    parameter int LEN_WIDTH = 8,
    parameter int NUM_SETS  = 64,
    parameter int WAYS      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] probe_key,
    input  logic                 probe_valid,
    input  logic                 probe_last,
    output logic                 probe_ready,
    output logic                 match_valid,
    output logic                 match_hit,
    output logic [ID_WIDTH-1:0]  match_id,
    output logic [LEN_WIDTH-1:0] match_len,
    output logic                 match_last,
    input  logic                 cfg_valid,
    input  logic                 cfg_op,
    input  logic [KEY_WIDTH-1:0] cfg_key,
    input  logic [ID_WIDTH-1:0]  cfg_match_id,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 cfg_ready,
    output logic                 cfg_done,
    output logic                 cfg_found,
    output logic                 cfg_evicted,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CHUNKS   = (KEY_WIDTH + SET_BITS - 1) / SET_BITS;
    localparam int PAD_W    = CHUNKS * SET_BITS;

    typedef enum logic [1:0] {IDLE, DRAIN, LOOKUP, COMMIT} state_t;
    state_t state_reg, state_next;

    function automatic logic [SET_BITS-1:0] fold_index(input logic [KEY_WIDTH-1:0] key);
        logic [PAD_W-1:0]    padded;
        logic [SET_BITS-1:0] acc;
        padded = '0;
        padded[KEY_WIDTH-1:0] = key;
        acc = '0;
        for (int i = 0; i < CHUNKS; i++) acc ^= padded[i*SET_BITS +: SET_BITS];
        return acc;
    endfunction

    logic probe_accept, cfg_accept, commit, evict;
    logic s1_valid_reg, s2_valid_reg, s1_last_reg, s2_last_reg;
    logic [KEY_WIDTH-1:0] s1_key_reg, s2_key_reg, cmp_key;
    logic [SET_BITS-1:0]  s1_set_reg, rd_set;

    logic                 cfg_op_reg;
    logic [KEY_WIDTH-1:0] cfg_key_reg;
    logic [ID_WIDTH-1:0]  cfg_id_reg;
    logic [LEN_WIDTH-1:0] cfg_len_reg;
    logic [SET_BITS-1:0]  cfg_set_reg;

    logic [WAYS-1:0]      way_hit, way_valid, wr_way, clr_way;
    logic [ID_WIDTH-1:0]  way_id  [WAYS];
    logic [LEN_WIDTH-1:0] way_len [WAYS];
    logic                 hit_any, free_any;
    logic [WAY_BITS-1:0]  hit_way, free_way, target_way, rr_next;

    logic                 lk_hit_reg, lk_free_reg;
    logic [WAY_BITS-1:0]  lk_hit_way_reg, lk_free_way_reg, lk_rr_reg;
    logic [WAY_BITS-1:0]  rr_reg [NUM_SETS];

    logic                 match_valid_reg, match_hit_reg, match_last_reg;
    logic [ID_WIDTH-1:0]  match_id_reg;
    logic [LEN_WIDTH-1:0] match_len_reg;
    logic [31:0]          hit_count_reg, miss_count_reg;

    assign cfg_ready    = (state_reg == IDLE);
    assign probe_ready  = (state_reg == IDLE) && !cfg_valid;
    assign probe_accept = probe_valid && probe_ready;
    assign cfg_accept   = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= probe_accept;
            s2_valid_reg <= s1_valid_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (probe_accept) begin
            s1_key_reg  <= probe_key;
            s1_set_reg  <= fold_index(probe_key);
            s1_last_reg <= probe_last;
        end
        s2_key_reg  <= s1_key_reg;
        s2_last_reg <= s1_last_reg;
        if (cfg_accept) begin
            cfg_op_reg  <= cfg_op;
            cfg_key_reg <= cfg_key;
            cfg_id_reg  <= cfg_match_id;
            cfg_len_reg <= cfg_len;
            cfg_set_reg <= fold_index(cfg_key);
        end
    end

    // Single read port: probes own it while idle, the config op owns it otherwise.
    assign rd_set  = (state_reg == IDLE) ? s1_set_reg : cfg_set_reg;
    assign cmp_key = (state_reg == LOOKUP) ? cfg_key_reg : s2_key_reg;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [KEY_WIDTH-1:0] key_mem [NUM_SETS];
            logic [ID_WIDTH-1:0]  id_mem  [NUM_SETS];
            logic [LEN_WIDTH-1:0] len_mem [NUM_SETS];
            logic [NUM_SETS-1:0]  valid_bits_reg;
            logic [KEY_WIDTH-1:0] rd_key_reg;
            logic [ID_WIDTH-1:0]  rd_id_reg;
            logic [LEN_WIDTH-1:0] rd_len_reg;
            logic                 rd_valid_reg;

            always_ff @(posedge clk) begin
                if (wr_way[gi]) begin
                    key_mem[cfg_set_reg] <= cfg_key_reg;
                    id_mem[cfg_set_reg]  <= cfg_id_reg;
                    len_mem[cfg_set_reg] <= cfg_len_reg;
                end
                rd_key_reg   <= key_mem[rd_set];
                rd_id_reg    <= id_mem[rd_set];
                rd_len_reg   <= len_mem[rd_set];
                rd_valid_reg <= valid_bits_reg[rd_set];
            end

            always_ff @(posedge clk) begin
                if (!rst_n)
                    valid_bits_reg <= '0;
                else if (wr_way[gi])
                    valid_bits_reg[cfg_set_reg] <= 1'b1;
                else if (clr_way[gi])
                    valid_bits_reg[cfg_set_reg] <= 1'b0;
            end

            assign way_valid[gi] = rd_valid_reg;
            assign way_hit[gi]   = rd_valid_reg && (rd_key_reg == cmp_key);
            assign way_id[gi]    = rd_id_reg;
            assign way_len[gi]   = rd_len_reg;
        end
    endgenerate

    // Scan downwards so the lowest matching / free way is the one kept.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(i);
            end
            if (!way_valid[i]) begin
                free_any = 1'b1;
                free_way = WAY_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == LOOKUP) begin
            lk_hit_reg      <= hit_any;
            lk_hit_way_reg  <= hit_way;
            lk_free_reg     <= free_any;
            lk_free_way_reg <= free_way;
            lk_rr_reg       <= rr_reg[cfg_set_reg];
        end
    end

    always_comb begin
        commit     = (state_reg == COMMIT);
        evict      = !cfg_op_reg && !lk_hit_reg && !lk_free_reg;
        target_way = lk_hit_reg ? lk_hit_way_reg : (lk_free_reg ? lk_free_way_reg : lk_rr_reg);
        rr_next    = (WAYS == 1) ? '0 : lk_rr_reg + 1'b1;
        wr_way     = '0;
        clr_way    = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (commit && !cfg_op_reg && target_way == WAY_BITS'(i)) wr_way[i] = 1'b1;
            if (commit && cfg_op_reg && lk_hit_reg && lk_hit_way_reg == WAY_BITS'(i)) clr_way[i] = 1'b1;
        end
    end

    assign cfg_done    = commit;
    assign cfg_found   = commit && lk_hit_reg;
    assign cfg_evicted = commit && evict;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SETS; i++) rr_reg[i] <= '0;
        end else if (commit && evict) begin
            rr_reg[cfg_set_reg] <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // DRAIN doubles as the read cycle for the config set.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_accept) state_next = DRAIN;
            DRAIN:   if (!s1_valid_reg && !s2_valid_reg) state_next = LOOKUP;
            LOOKUP:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_valid_reg <= 1'b0;
            match_hit_reg   <= 1'b0;
            match_id_reg    <= '0;
            match_len_reg   <= '0;
            match_last_reg  <= 1'b0;
        end else begin
            match_valid_reg <= s2_valid_reg;
            match_hit_reg   <= s2_valid_reg && hit_any;
            match_id_reg    <= (s2_valid_reg && hit_any) ? way_id[hit_way] : '0;
            match_len_reg   <= (s2_valid_reg && hit_any) ? way_len[hit_way] : '0;
            match_last_reg  <= s2_valid_reg && s2_last_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (match_valid_reg) begin
            if (match_hit_reg) begin
                if (hit_count_reg != 32'hFFFF_FFFF) hit_count_reg <= hit_count_reg + 32'd1;
            end else begin
                if (miss_count_reg != 32'hFFFF_FFFF) miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign match_valid = match_valid_reg;
    assign match_hit   = match_hit_reg;
    assign match_id    = match_id_reg;
    assign match_len   = match_len_reg;
    assign match_last  = match_last_reg;
    assign hit_count   = hit_count_reg;
    assign miss_count  = miss_count_reg;
endmodule

// File: tb/tb_cam_bank_assoc.sv
// Directed bench for cam_bank_assoc: insert/evict/delete tables, probe tables,
// back-to-back burst, config-vs-inflight ordering, counter saturation, mid-burst reset.
module tb_cam_bank_assoc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] probe_key;
    logic        probe_valid, probe_last, probe_ready;
    logic        match_valid, match_hit, match_last;
    logic [31:0] match_id;
    logic [7:0]  match_len;
    logic        cfg_valid, cfg_op, cfg_ready, cfg_done, cfg_found, cfg_evicted;
    logic [95:0] cfg_key;
    logic [31:0] cfg_match_id;
    logic [7:0]  cfg_len;
    logic [31:0] hit_count, miss_count;

    int compared   = 0;
    int mismatched = 0;

    cam_bank_assoc dut (
        .clk(clk), .rst_n(rst_n),
        .probe_key(probe_key), .probe_valid(probe_valid), .probe_last(probe_last),
        .probe_ready(probe_ready),
        .match_valid(match_valid), .match_hit(match_hit), .match_id(match_id),
        .match_len(match_len), .match_last(match_last),
        .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_key(cfg_key),
        .cfg_match_id(cfg_match_id), .cfg_len(cfg_len), .cfg_ready(cfg_ready),
        .cfg_done(cfg_done), .cfg_found(cfg_found), .cfg_evicted(cfg_evicted),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        op;
        logic [95:0] key;
        logic [31:0] id;
        logic [7:0]  len;
        logic        exp_found;
        logic        exp_evicted;
    } cfg_vec_t;

    typedef struct {
        logic [95:0] key;
        logic        exp_hit;
        logic [31:0] exp_id;
        logic [7:0]  exp_len;
    } probe_vec_t;

    cfg_vec_t   cfg_tab [6];
    probe_vec_t prb_tab [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_probe(input logic [95:0] key, output logic hit, output logic [31:0] id,
                            output logic [7:0] len, output int lat);
        check("probe_ready_before_probe", probe_ready, 1'b1);
        probe_valid = 1'b1;
        probe_key   = key;
        probe_last  = 1'b0;
        tick();
        probe_valid = 1'b0;
        lat = 0; hit = 1'b0; id = '0; len = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (match_valid) begin
                lat = c; hit = match_hit; id = match_id; len = match_len;
                break;
            end
        end
        $display("probe key=%0h lat=%0d hit=%0b id=%0h len=%0d", key, lat, hit, id, len);
    endtask

    task automatic do_cfg(input logic op, input logic [95:0] key, input logic [31:0] id,
                          input logic [7:0] len, output logic found, output logic ev, output int cyc);
        check("cfg_ready_before_cfg", cfg_ready, 1'b1);
        cfg_valid = 1'b1; cfg_op = op; cfg_key = key; cfg_match_id = id; cfg_len = len;
        tick();
        cfg_valid = 1'b0;
        cyc = 0; found = 1'b0; ev = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (cfg_done) begin
                cyc = c; found = cfg_found; ev = cfg_evicted;
                break;
            end
        end
        tick();
        $display("cfg op=%0b key=%0h cycles=%0d found=%0b evicted=%0b", op, key, cyc, found, ev);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic        r_hit, r_found, r_ev;
    logic [31:0] r_id;
    logic [7:0]  r_len;
    int          r_lat, r_cyc;

    initial begin
        cfg_tab[0] = '{1'b0, 96'h1,   32'h11, 8'd1, 1'b0, 1'b0};
        cfg_tab[1] = '{1'b0, 96'h40,  32'h22, 8'd2, 1'b0, 1'b0};
        cfg_tab[2] = '{1'b0, 96'h83,  32'h33, 8'd3, 1'b0, 1'b0};
        cfg_tab[3] = '{1'b0, 96'hC2,  32'h44, 8'd4, 1'b0, 1'b0};
        cfg_tab[4] = '{1'b0, 96'h105, 32'h55, 8'd5, 1'b0, 1'b1};
        cfg_tab[5] = '{1'b0, 96'h144, 32'h66, 8'd6, 1'b0, 1'b1};
        prb_tab[0] = '{96'h1,   1'b0, 32'h0,  8'd0};
        prb_tab[1] = '{96'h40,  1'b1, 32'h22, 8'd2};
        prb_tab[2] = '{96'h83,  1'b1, 32'h33, 8'd3};
        prb_tab[3] = '{96'hC2,  1'b1, 32'h44, 8'd4};
        prb_tab[4] = '{96'h105, 1'b1, 32'h55, 8'd5};
        prb_tab[5] = '{96'h40,  1'b0, 32'h0,  8'd0};
        prb_tab[6] = '{96'h144, 1'b1, 32'h66, 8'd6};

        probe_valid = 0; probe_last = 0; probe_key = '0;
        cfg_valid = 0; cfg_op = 0; cfg_key = '0; cfg_match_id = '0; cfg_len = '0;
        apply_reset();

        check("reset_probe_ready", probe_ready, 1'b1);
        check("reset_cfg_ready", cfg_ready, 1'b1);
        check("reset_match_valid", match_valid, 1'b0);
        check("reset_cfg_done", cfg_done, 1'b0);
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);

        // Empty table miss with exact latency
        do_probe(96'hDEADBEEF_11223344_55667788, r_hit, r_id, r_len, r_lat);
        check("t1_latency", r_lat, 2);
        check("t1_hit", r_hit, 1'b0);
        check("t1_id", r_id, 32'h0);
        check("t1_len", r_len, 8'd0);
        tick();
        check("t1_miss_count", miss_count, 32'd1);
        check("t1_hit_count", hit_count, 32'd0);

        // Insert then update in place
        do_cfg(1'b0, 96'h1, 32'hA5, 8'd12, r_found, r_ev, r_cyc);
        check("t2_cfg_done_seen", r_cyc > 0, 1'b1);
        check("t2_found", r_found, 1'b0);
        check("t2_evicted", r_ev, 1'b0);
        do_probe(96'h1, r_hit, r_id, r_len, r_lat);
        check("t2_latency", r_lat, 2);
        check("t2_hit", r_hit, 1'b1);
        check("t2_id", r_id, 32'hA5);
        check("t2_len", r_len, 8'd12);
        do_cfg(1'b0, 96'h1, 32'h5A, 8'd12, r_found, r_ev, r_cyc);
        check("t2_reinsert_found", r_found, 1'b1);
        check("t2_reinsert_evicted", r_ev, 1'b0);
        do_probe(96'h1, r_hit, r_id, r_len, r_lat);
        check("t2_updated_id", r_id, 32'h5A);

        // Six keys folding to set 1: fifth and sixth evict in round-robin order
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_cfg(cfg_tab[i].op, cfg_tab[i].key, cfg_tab[i].id, cfg_tab[i].len, r_found, r_ev, r_cyc);
            check($sformatf("t3_cfg%0d_found", i), r_found, cfg_tab[i].exp_found);
            check($sformatf("t3_cfg%0d_evicted", i), r_ev, cfg_tab[i].exp_evicted);
        end
        for (int i = 0; i < 5; i++) begin
            do_probe(prb_tab[i].key, r_hit, r_id, r_len, r_lat);
            check($sformatf("t3_prb%0d_hit", i), r_hit, prb_tab[i].exp_hit);
            check($sformatf("t3_prb%0d_id", i), r_id, prb_tab[i].exp_id);
            check($sformatf("t3_prb%0d_len", i), r_len, prb_tab[i].exp_len);
        end
        do_cfg(cfg_tab[5].op, cfg_tab[5].key, cfg_tab[5].id, cfg_tab[5].len, r_found, r_ev, r_cyc);
        check("t3_cfg5_evicted", r_ev, cfg_tab[5].exp_evicted);
        for (int i = 5; i < 7; i++) begin
            do_probe(prb_tab[i].key, r_hit, r_id, r_len, r_lat);
            check($sformatf("t3_prb%0d_hit", i), r_hit, prb_tab[i].exp_hit);
            check($sformatf("t3_prb%0d_id", i), r_id, prb_tab[i].exp_id);
        end
        tick();

        // 1000 back-to-back probes, alternating hit (0x83) and miss
        begin
            int pulses = 0, first = -1, lastp = -1, last_flags = 0, last_at = -1, rdy_bad = 0, bad_hits = 0;
            logic [31:0] h0, m0;
            h0 = hit_count; m0 = miss_count;
            for (int c = 0; c < 1010; c++) begin
                probe_valid = (c < 1000);
                probe_key   = (c % 2 == 0) ? 96'h83 : 96'hDEAD;
                probe_last  = (c == 999);
                if (c < 1000 && !probe_ready) rdy_bad++;
                tick();
                if (match_valid) begin
                    if (match_hit !== ((pulses % 2) == 0)) bad_hits++;
                    pulses++;
                    if (first < 0) first = c;
                    lastp = c;
                    if (match_last) begin last_flags++; last_at = c; end
                end
            end
            probe_valid = 0; probe_last = 0;
            tick();
            $display("burst pulses=%0d first=%0d last=%0d last_at=%0d", pulses, first, lastp, last_at);
            check("t4_ready_held", rdy_bad, 0);
            check("t4_pulses", pulses, 1000);
            check("t4_first_latency", first, 2);
            check("t4_consecutive", lastp - first, 999);
            check("t4_last_count", last_flags, 1);
            check("t4_last_position", last_at, 1001);
            check("t4_hit_pattern", bad_hits, 0);
            check("t4_hit_delta", hit_count - h0, 32'd500);
            check("t4_miss_delta", miss_count - m0, 32'd500);
        end

        // Delete arriving behind two in-flight probes
        begin
            int rdy_bad = 0;
            logic seen_done = 1'b0;
            probe_valid = 1'b1; probe_key = 96'h83;
            tick();
            tick();
            probe_valid = 1'b0;
            cfg_valid = 1'b1; cfg_op = 1'b1; cfg_key = 96'h83;
            check("t5_cfg_ready", cfg_ready, 1'b1);
            tick();
            cfg_valid = 1'b0;
            check("t5_r1_valid", match_valid, 1'b1);
            check("t5_r1_hit", match_hit, 1'b1);
            check("t5_r1_id", match_id, 32'h33);
            check("t5_ready_low", probe_ready, 1'b0);
            tick();
            check("t5_r2_valid", match_valid, 1'b1);
            check("t5_r2_hit", match_hit, 1'b1);
            check("t5_r2_id", match_id, 32'h33);
            for (int c = 0; c < 20; c++) begin
                if (probe_ready) rdy_bad++;
                if (cfg_done) begin
                    seen_done = 1'b1;
                    check("t5_del_found", cfg_found, 1'b1);
                    break;
                end
                tick();
            end
            check("t5_cfg_done_seen", seen_done, 1'b1);
            check("t5_ready_low_until_done", rdy_bad, 0);
            tick();
            check("t5_ready_after_done", probe_ready, 1'b1);
            $display("delete-inflight done=%0b ready_violations=%0d", seen_done, rdy_bad);
        end
        do_probe(96'h83, r_hit, r_id, r_len, r_lat);
        check("t5_deleted_miss", r_hit, 1'b0);
        do_cfg(1'b1, 96'h999, 32'h0, 8'd0, r_found, r_ev, r_cyc);
        check("t5_absent_delete_found", r_found, 1'b0);

        // Miss counter saturation
        force dut.miss_count_reg = 32'hFFFF_FFFD;
        tick();
        release dut.miss_count_reg;
        do_probe(96'hDEAD, r_hit, r_id, r_len, r_lat);
        tick();
        check("t6_miss_fffe", miss_count, 32'hFFFF_FFFE);
        do_probe(96'hDEAD, r_hit, r_id, r_len, r_lat);
        tick();
        check("t6_miss_ffff", miss_count, 32'hFFFF_FFFF);
        do_probe(96'hDEAD, r_hit, r_id, r_len, r_lat);
        tick();
        check("t6_miss_saturated", miss_count, 32'hFFFF_FFFF);

        // Reset in the middle of a burst
        begin
            int stray = 0;
            probe_valid = 1'b1; probe_key = 96'hDEAD;
            for (int c = 0; c < 6; c++) tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            probe_valid = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (match_valid) stray++;
                tick();
            end
            $display("mid-burst reset stray_results=%0d", stray);
            check("t6_no_results_after_reset", stray, 0);
            check("t6_hit_cleared", hit_count, 32'd0);
            check("t6_miss_cleared", miss_count, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
